// File: rtl/bcp_core.sv
// bcp_core: Boolean-constraint-propagation engine.
// Scans an inclusive clause range, classifies each clause against the
// current variable state, pushes unit implications onto the imply stack
// and reports the first falsified clause. One clause costs three cycles
// (FETCH, VSREAD, EVAL) plus any cycles spent waiting on a full imply stack.
module bcp_core #(
  parameter int MAX_VARS_BITS    = 8,
  parameter int MAX_CLAUSES_BITS = 10,
  parameter int LITS             = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          reset_bcp,
  input  logic                          bcp_en,
  input  logic [MAX_CLAUSES_BITS-1:0]   start_clause,
  input  logic [MAX_CLAUSES_BITS-1:0]   end_clause,
  output logic                          bcp_busy,
  output logic                          conflict,
  output logic [MAX_CLAUSES_BITS-1:0]   bcp_clause_idx,
  output logic                          clause_rd,
  output logic [MAX_CLAUSES_BITS-1:0]   clause_addr,
  input  logic [LITS*MAX_VARS_BITS-1:0] clause_var,
  input  logic [LITS-1:0]               clause_pol,
  input  logic [LITS-1:0]               clause_lit_valid,
  output logic                          vs_rd,
  output logic [LITS*MAX_VARS_BITS-1:0] vs_var,
  input  logic [LITS-1:0]               vs_val,
  input  logic [LITS-1:0]               vs_assigned,
  output logic                          push_imply,
  output logic [MAX_VARS_BITS-1:0]      var_in_imply,
  output logic                          val_in_imply,
  input  logic                          full_imply
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_VSREAD = 3'd2,
    S_EVAL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // True when exactly one bit of the literal vector is set.
  function automatic logic exactly_one(input logic [LITS-1:0] v);
    logic [LITS-1:0] zero_v;
    zero_v = {LITS{1'b0}};
    return (v != zero_v) && ((v & (v - LITS'(1))) == zero_v);
  endfunction

  state_t                          state_r;
  logic [MAX_CLAUSES_BITS-1:0]     idx_r;
  logic [MAX_CLAUSES_BITS-1:0]     end_r;
  logic                            busy_r;
  logic                            conflict_r;
  logic                            clause_rd_r;
  logic [MAX_CLAUSES_BITS-1:0]     clause_addr_r;
  logic                            vs_rd_r;
  logic                            push_r;
  logic [MAX_VARS_BITS-1:0]        push_var_r;
  logic                            push_val_r;
  logic [LITS*MAX_VARS_BITS-1:0]   cvar_r;
  logic [LITS-1:0]                 cpol_r;
  logic [LITS-1:0]                 cvalid_r;
  // A unit clause waiting for room on the imply stack keeps its literal here,
  // so the var-state read data no longer needs to be held by the memory.
  logic                            held_r;
  logic [MAX_VARS_BITS-1:0]        held_var_r;
  logic                            held_pol_r;

  logic [LITS-1:0]                 lit_sat_s;
  logic [LITS-1:0]                 lit_free_s;
  logic [MAX_VARS_BITS-1:0]        free_var_s;
  logic                            free_pol_s;
  logic                            unit_s;
  logic                            conflict_s;
  logic [MAX_VARS_BITS-1:0]        unit_var_s;
  logic                            unit_pol_s;
  logic                            last_s;

  // Per-literal classification of the registered clause against var state.
  always_comb begin
    lit_sat_s  = {LITS{1'b0}};
    lit_free_s = {LITS{1'b0}};
    free_var_s = {MAX_VARS_BITS{1'b0}};
    free_pol_s = 1'b0;
    for (int i = LITS - 1; i >= 0; i--) begin
      lit_sat_s[i]  = cvalid_r[i] & vs_assigned[i] & ~(vs_val[i] ^ cpol_r[i]);
      lit_free_s[i] = cvalid_r[i] & ~vs_assigned[i];
      free_var_s    = lit_free_s[i] ? cvar_r[i*MAX_VARS_BITS +: MAX_VARS_BITS] : free_var_s;
      free_pol_s    = lit_free_s[i] ? cpol_r[i] : free_pol_s;
    end
  end

  // Clause-level outcome; a held unit clause is not re-evaluated.
  always_comb begin
    unit_s     = held_r | (~(|lit_sat_s) & exactly_one(lit_free_s));
    conflict_s = ~held_r & ~(|lit_sat_s) & ~(|lit_free_s);
    unit_var_s = held_r ? held_var_r : free_var_s;
    unit_pol_s = held_r ? held_pol_r : free_pol_s;
    last_s     = (idx_r == end_r);
  end

  // Scan sequencer with all interface outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      idx_r         <= {MAX_CLAUSES_BITS{1'b0}};
      end_r         <= {MAX_CLAUSES_BITS{1'b0}};
      busy_r        <= 1'b0;
      conflict_r    <= 1'b0;
      clause_rd_r   <= 1'b0;
      clause_addr_r <= {MAX_CLAUSES_BITS{1'b0}};
      vs_rd_r       <= 1'b0;
      push_r        <= 1'b0;
      push_var_r    <= {MAX_VARS_BITS{1'b0}};
      push_val_r    <= 1'b0;
      cvar_r        <= {(LITS*MAX_VARS_BITS){1'b0}};
      cpol_r        <= {LITS{1'b0}};
      cvalid_r      <= {LITS{1'b0}};
      held_r        <= 1'b0;
      held_var_r    <= {MAX_VARS_BITS{1'b0}};
      held_pol_r    <= 1'b0;
    end else if (reset_bcp) begin
      state_r       <= S_IDLE;
      idx_r         <= {MAX_CLAUSES_BITS{1'b0}};
      end_r         <= {MAX_CLAUSES_BITS{1'b0}};
      busy_r        <= 1'b0;
      conflict_r    <= 1'b0;
      clause_rd_r   <= 1'b0;
      clause_addr_r <= {MAX_CLAUSES_BITS{1'b0}};
      vs_rd_r       <= 1'b0;
      push_r        <= 1'b0;
      push_var_r    <= {MAX_VARS_BITS{1'b0}};
      push_val_r    <= 1'b0;
      cvar_r        <= {(LITS*MAX_VARS_BITS){1'b0}};
      cpol_r        <= {LITS{1'b0}};
      cvalid_r      <= {LITS{1'b0}};
      held_r        <= 1'b0;
      held_var_r    <= {MAX_VARS_BITS{1'b0}};
      held_pol_r    <= 1'b0;
    end else begin
      clause_rd_r <= 1'b0;
      vs_rd_r     <= 1'b0;
      push_r      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bcp_en) begin
            idx_r      <= start_clause;
            end_r      <= end_clause;
            conflict_r <= 1'b0;
            if (start_clause > end_clause) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
            end else begin
              state_r       <= S_FETCH;
              busy_r        <= 1'b1;
              clause_rd_r   <= 1'b1;
              clause_addr_r <= start_clause;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_FETCH: begin
          state_r <= S_VSREAD;
          vs_rd_r <= 1'b1;
        end
        S_VSREAD: begin
          cvar_r   <= clause_var;
          cpol_r   <= clause_pol;
          cvalid_r <= clause_lit_valid;
          held_r   <= 1'b0;
          state_r  <= S_EVAL;
        end
        S_EVAL: begin
          if (conflict_s) begin
            conflict_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= S_DONE;
          end else if (unit_s && full_imply) begin
            held_r     <= 1'b1;
            held_var_r <= unit_var_s;
            held_pol_r <= unit_pol_s;
            state_r    <= S_EVAL;
          end else begin
            held_r <= 1'b0;
            if (unit_s) begin
              push_r     <= 1'b1;
              push_var_r <= unit_var_s;
              push_val_r <= unit_pol_s;
            end else begin
              push_r <= 1'b0;
            end
            // Compare before incrementing so the top clause index never wraps.
            if (last_s) begin
              busy_r  <= 1'b0;
              state_r <= S_DONE;
            end else begin
              idx_r         <= idx_r + MAX_CLAUSES_BITS'(1);
              clause_rd_r   <= 1'b1;
              clause_addr_r <= idx_r + MAX_CLAUSES_BITS'(1);
              state_r       <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bcp_busy       = busy_r;
  assign conflict       = conflict_r;
  assign bcp_clause_idx = idx_r;
  assign clause_rd      = clause_rd_r;
  assign clause_addr    = clause_addr_r;
  assign vs_rd          = vs_rd_r;
  // The var-state address is the clause data arriving this cycle; gating it
  // with the registered read strobe keeps it at zero outside VSREAD.
  assign vs_var         = vs_rd_r ? clause_var : {(LITS*MAX_VARS_BITS){1'b0}};
  assign push_imply     = push_r;
  assign var_in_imply   = push_var_r;
  assign val_in_imply   = push_val_r;

endmodule

// File: doc/bcp_core.md
# bcp_core

Boolean-constraint-propagation engine for the DPLL solver. Sits directly downstream of `control`: on `bcp_en` it scans the inclusive clause range [`start_clause`, `end_clause`] supplied by the var start/end table. For each clause it reads the clause literals and their var-state values and classifies the clause. Every unit implication is pushed onto the imply stack. The first falsified clause is reported to `control` through `conflict`/`bcp_clause_idx`.

## Interface
- `MAX_VARS_BITS`, 8, width of a variable index
- `MAX_CLAUSES_BITS`, 10, width of a clause index
- `LITS`, 3, literals per clause (fixed at 3 for this revision)

- `clock` in 1: single clock, rising-edge
- `reset` in 1: asynchronous, active-low (0 = in reset)
- `reset_bcp` in 1: synchronous clear from `control`; same effect as reset, takes priority over everything else
- `bcp_en` in 1: start pulse, sampled only in IDLE
- `start_clause`, `end_clause` in `MAX_CLAUSES_BITS`: scan range, sampled with `bcp_en`
- `bcp_busy` out 1: scan in progress
- `conflict` out 1: falsified clause found; held until next accepted `bcp_en`, `reset_bcp` or reset
- `bcp_clause_idx` out `MAX_CLAUSES_BITS`: clause currently being scanned; frozen at the conflicting clause on conflict
- `clause_rd` out 1, `clause_addr` out `MAX_CLAUSES_BITS`: clause memory read; data valid the following cycle
- `clause_var` in `LITS*MAX_VARS_BITS`, `clause_pol` in `LITS`, `clause_lit_valid` in `LITS`: clause data. `pol`=1 means positive literal.
- `vs_rd` out 1, `vs_var` out `LITS*MAX_VARS_BITS`: var-state read, three ports; data valid the following cycle
- `vs_val` in `LITS`, `vs_assigned` in `LITS`: var-state data
- `push_imply` out 1, `var_in_imply` out `MAX_VARS_BITS`, `val_in_imply` out 1: imply stack write
- `full_imply` in 1: imply stack full

## Operation
- States: IDLE, FETCH, VSREAD, EVAL, DONE.
- **IDLE**
  - On `bcp_en`, latch the range and set clause counter `idx` = `start_clause`.
  - Clear `conflict`.
  - If `start_clause > end_clause`, go to DONE. Otherwise go to FETCH.
- **FETCH**: assert `clause_rd` with `clause_addr` = `idx` → VSREAD.
- **VSREAD**
  - Register the clause data.
  - Assert `vs_rd` with `vs_var` = `clause_var` → EVAL.
- **EVAL**: for each valid literal, evaluate:
  - satisfied = assigned && (val == pol)
  - false = assigned && (val != pol)
  - free = !assigned
- **EVAL outcomes**
  - Any literal satisfied, or ≥2 free: next clause.
  - Exactly 1 free and none satisfied: unit. Push (var, `pol`) when `!full_imply`, then next clause. While `full_imply`=1, stay in EVAL with no push.
  - 0 free and none satisfied: conflict. Set `conflict`=1, freeze `bcp_clause_idx`, go to DONE. This includes a clause with all `clause_lit_valid`=0.
- **Next clause**: if `idx == end_clause`, go to DONE. Otherwise `idx`+1 and go to FETCH. Compare before incrementing, so `end_clause` = 2^`MAX_CLAUSES_BITS`−1 does not wrap.
- **DONE**: one cycle with `bcp_busy`=0, then IDLE.
- BCP never writes var state. Duplicate or contradictory implications are pushed as-is; `control` resolves them on the following propagation pass.
- `bcp_en` outside IDLE is ignored.

## Timing
- Reset or `reset_bcp`: state IDLE.
  - `bcp_busy`, `conflict`, `clause_rd`, `vs_rd`, `push_imply` = 0.
  - `bcp_clause_idx`, `clause_addr`, `vs_var`, `var_in_imply`, `val_in_imply` = 0.
- `bcp_busy`:
  - Rises the cycle after the accepted `bcp_en`.
  - Stays 1 through FETCH/VSREAD/EVAL.
  - Falls on entering DONE, so `conflict` is valid in the same cycle `bcp_busy` falls.
- Throughput: 3 cycles per clause with no stall. N clauses cost 3N cycles of `bcp_busy`, plus stall cycles.
- `push_imply` is registered and asserted for exactly one cycle per implication.
- Reset or `reset_bcp` asserted mid-scan aborts immediately. No push is issued after it.

## Test plan
- Clauses 0–2 all satisfied by var state, `bcp_en` with range 0–2 → `bcp_busy` high for 9 cycles; `conflict`=0; no `push_imply`.
- Clause 5 = (x3 ∨ ¬x7 ∨ x9) with x3=0, x7=1 assigned and x9 free; range 5–5 → exactly one push of (9, 1); `conflict`=0.
- Range 0–10 with clause 4 fully falsified → `conflict`=1, `bcp_clause_idx`=4, `bcp_busy` low at cycle 15; clauses 5–10 never fetched.
- Unit clause with `full_imply` held for 4 cycles → push occurs on the first cycle `full_imply`=0; `bcp_busy` extended by 4 cycles.
- `start_clause`=7, `end_clause`=3 → `bcp_busy` never asserted; DONE reached, `conflict`=0. Separately, range 1023–1023 → single clause scanned, no wrap.
- Pulse `reset_bcp` during the EVAL of a unit clause → no push; all outputs return to reset values the next cycle; a subsequent `bcp_en` scans normally.
